// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter with a built-in prescaler, synchronous clear/load,
// wrap or saturate at the limit, and tick/rollover pulses for cascading.
module bcd_counter_multi #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000000,
    parameter int WRAP     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tick,
    output logic                  rollover
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]         presc_reg, presc_next;
    logic [4*DIGITS-1:0]   bcd_reg, bcd_next;
    logic                  tick_reg, tick_next;
    logic                  rollover_reg, rollover_next;

    logic                  step;
    logic                  limit_hit;
    logic [DIGITS:0]       nine_chain;
    logic [DIGITS:0]       zero_chain;
    logic [4*DIGITS-1:0]   step_val;
    logic [4*DIGITS-1:0]   load_clamped;

    assign step = en && (presc_reg == PMAX);

    // nine_chain[k] / zero_chain[k]: every digit below k is 9 / 0, i.e. digit k
    // receives the carry / borrow. Index DIGITS covers the whole value.
    assign nine_chain[0] = 1'b1;
    assign zero_chain[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] cur;
            logic [3:0] inc_d;
            logic [3:0] dec_d;
            logic [3:0] ld_d;

            assign cur   = bcd_reg[4*gi +: 4];
            assign inc_d = (cur >= 4'd9) ? 4'd0 : cur + 4'd1;
            assign dec_d = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
            assign ld_d  = load_val[4*gi +: 4];

            assign nine_chain[gi+1] = nine_chain[gi] && (cur == 4'd9);
            assign zero_chain[gi+1] = zero_chain[gi] && (cur == 4'd0);

            assign step_val[4*gi +: 4] = up_dn ? (nine_chain[gi] ? inc_d : cur)
                                               : (zero_chain[gi] ? dec_d : cur);
            assign load_clamped[4*gi +: 4] = (ld_d > 4'd9) ? 4'd9 : ld_d;
        end
    endgenerate

    assign limit_hit = up_dn ? nine_chain[DIGITS] : zero_chain[DIGITS];

    always_comb begin
        presc_next    = presc_reg;
        bcd_next      = bcd_reg;
        tick_next     = 1'b0;
        rollover_next = 1'b0;
        if (clr) begin
            presc_next = '0;
            bcd_next   = '0;
        end else if (load) begin
            // A step falling on this edge is dropped; the new period starts fresh.
            presc_next = '0;
            bcd_next   = load_clamped;
        end else if (en) begin
            presc_next = step ? '0 : presc_reg + PW'(1);
            if (step) begin
                tick_next     = 1'b1;
                rollover_next = limit_hit;
                if (!(limit_hit && (WRAP == 0))) begin
                    bcd_next = step_val;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg    <= '0;
            bcd_reg      <= '0;
            tick_reg     <= 1'b0;
            rollover_reg <= 1'b0;
        end else begin
            presc_reg    <= presc_next;
            bcd_reg      <= bcd_next;
            tick_reg     <= tick_next;
            rollover_reg <= rollover_next;
        end
    end

    assign bcd      = bcd_reg;
    assign tick     = tick_reg;
    assign rollover = rollover_reg;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Directed bench: wrapping, saturating and PRESCALE=1 counters on shared inputs.
module tb_bcd_counter_multi;

    logic       clk = 1'b0;
    logic       rst, en, clr, up_dn, load;
    logic [7:0] load_val;

    logic [7:0] bcd_w, bcd_s, bcd_f;
    logic       tick_w, tick_s, tick_f;
    logic       roll_w, roll_s, roll_f;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_counter_multi #(.DIGITS(2), .PRESCALE(4), .WRAP(1)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .up_dn(up_dn), .load(load),
        .load_val(load_val), .bcd(bcd_w), .tick(tick_w), .rollover(roll_w));

    bcd_counter_multi #(.DIGITS(2), .PRESCALE(4), .WRAP(0)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .up_dn(up_dn), .load(load),
        .load_val(load_val), .bcd(bcd_s), .tick(tick_s), .rollover(roll_s));

    bcd_counter_multi #(.DIGITS(2), .PRESCALE(1), .WRAP(1)) dut_fast (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .up_dn(up_dn), .load(load),
        .load_val(load_val), .bcd(bcd_f), .tick(tick_f), .rollover(roll_f));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Three quiet cycles, then the stepping cycle of a PRESCALE=4 period.
    task automatic period_wrap(input string tag, input logic [7:0] exp_bcd, input logic exp_roll);
        for (int c = 0; c < 3; c++) begin
            cyc();
            check({tag, " quiet tick"}, {7'd0, tick_w}, 8'd0);
        end
        cyc();
        check({tag, " bcd"}, bcd_w, exp_bcd);
        check({tag, " tick"}, {7'd0, tick_w}, 8'd1);
        check({tag, " roll"}, {7'd0, roll_w}, {7'd0, exp_roll});
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
        cyc(); cyc();
        check("reset bcd", bcd_w, 8'h00);
        check("reset tick", {7'd0, tick_w}, 8'd0);
        check("reset roll", {7'd0, roll_w}, 8'd0);
        rst = 1'b0;
        en = 1'b1;

        // Count up 01..10, one step per 4 clocks
        for (int v = 1; v <= 10; v++) begin
            period_wrap($sformatf("up %0d", v), 8'((v / 10) * 16 + (v % 10)), 1'b0);
        end

        // Wrap vs saturate at 99
        do_load(8'h98);
        check("load 98", bcd_w, 8'h98);
        check("load 98 tick", {7'd0, tick_w}, 8'd0);
        period_wrap("up 99", 8'h99, 1'b0);
        period_wrap("wrap 00", 8'h00, 1'b1);
        check("sat hold 99", bcd_s, 8'h99);
        check("sat roll 1", {7'd0, roll_s}, 8'd1);
        period_wrap("wrap 01", 8'h01, 1'b0);
        check("sat hold 99 again", bcd_s, 8'h99);
        check("sat roll again", {7'd0, roll_s}, 8'd1);

        // Count down through 00
        up_dn = 1'b0;
        do_load(8'h01);
        period_wrap("down 00", 8'h00, 1'b0);
        period_wrap("down wrap 99", 8'h99, 1'b1);
        check("sat down hold 00", bcd_s, 8'h00);
        check("sat down roll", {7'd0, roll_s}, 8'd1);
        do_load(8'h10);
        period_wrap("borrow 09", 8'h09, 1'b0);

        // Load clamping of invalid nibbles
        do_load(8'h3A);
        check("clamp 39", bcd_w, 8'h39);
        do_load(8'hF3);
        check("clamp 93", bcd_w, 8'h93);

        // Load on a step edge: no tick, full period afterwards
        cyc(); cyc(); cyc();
        do_load(8'h25);
        check("load on step bcd", bcd_w, 8'h25);
        check("load on step tick", {7'd0, tick_w}, 8'd0);
        period_wrap("after load step", 8'h24, 1'b0);

        // Freeze mid-period; direction change during freeze applies to next step
        cyc(); cyc();
        en = 1'b0;
        up_dn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            check("frozen tick", {7'd0, tick_w}, 8'd0);
        end
        check("frozen bcd", bcd_w, 8'h24);
        en = 1'b1;
        cyc();
        check("resume quiet", {7'd0, tick_w}, 8'd0);
        check("resume quiet bcd", bcd_w, 8'h24);
        cyc();
        check("resume step bcd", bcd_w, 8'h25);
        check("resume step tick", {7'd0, tick_w}, 8'd1);

        // clr beats load on the same edge
        clr = 1'b1;
        do_load(8'h77);
        clr = 1'b0;
        check("clr over load", bcd_w, 8'h00);
        check("clr tick", {7'd0, tick_w}, 8'd0);

        // Asynchronous reset mid-period at 57
        do_load(8'h57);
        cyc();
        #2;
        rst = 1'b1;
        #1;
        check("async rst bcd", bcd_w, 8'h00);
        check("async rst sat bcd", bcd_s, 8'h00);
        check("async rst tick", {7'd0, tick_w}, 8'd0);
        check("async rst roll", {7'd0, roll_w}, 8'd0);
        cyc();
        rst = 1'b0;

        // PRESCALE=1 steps every enabled clock
        for (int v = 1; v <= 5; v++) begin
            cyc();
            check($sformatf("fast bcd %0d", v), bcd_f, 8'(v));
            check($sformatf("fast tick %0d", v), {7'd0, tick_f}, 8'd1);
        end
        en = 1'b0;
        cyc();
        check("fast disabled bcd", bcd_f, 8'h05);
        check("fast disabled tick", {7'd0, tick_f}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
